// File: rtl/i2c_datapath.sv
// rtl/i2c_datapath.sv - bit-level I2C datapath: SCL divider, transmit shifter, SDA mux, ack capture
//
// Ports:
//   clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-high
//   BaudEnable   in   1 = run SCL divider; 0 = SCL held high, divider cleared
//   WriteLoad    in   load WriteData into the shift register (highest priority)
//   ShiftorHold  in   one-cycle pulse: shift register left by one
//   Select       in   SDA source: 1 = shift register MSB, 0 = StartStopAck
//   StartStopAck in   SDA level when Select = 0
//   ReadOrWrite  in   1 = release SDA and sample the acknowledge on SCL rise
//   WriteData    in   byte to transmit
//   SDA_in       in   SDA pad input (asynchronous)
//   ClockI2C     out  registered SCL level
//   SDA_oe       out  1 = pull SDA low, 0 = release
//   SDA_level    out  registered intended SDA level
//   AckReceived  out  last captured acknowledge, 1 = slave pulled SDA low
//   AckValid     out  one-cycle pulse when AckReceived updates
//   ShiftData    out  current shift register contents

module i2c_datapath #(
  parameter int HALF_PERIOD = 500
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       BaudEnable,
  input  logic       WriteLoad,
  input  logic       ShiftorHold,
  input  logic       Select,
  input  logic       StartStopAck,
  input  logic       ReadOrWrite,
  input  logic [7:0] WriteData,
  input  logic       SDA_in,
  output logic       ClockI2C,
  output logic       SDA_oe,
  output logic       SDA_level,
  output logic       AckReceived,
  output logic       AckValid,
  output logic [7:0] ShiftData
);

  localparam logic [15:0] LP_DIV_MAX = 16'(HALF_PERIOD - 1);

  logic [15:0] r_div;
  logic        r_scl;
  logic [7:0]  r_shift;
  logic        r_sda_level;
  logic        r_sda_oe;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_ack;
  logic        r_ack_valid;

  logic        w_div_wrap;
  logic        w_scl_rise;
  logic        w_level;

  // The toggle happens on the edge that ends this cycle; scl_rise marks the
  // cycle whose edge drives SCL from low to high.
  assign w_div_wrap = BaudEnable && (r_div == LP_DIV_MAX);
  assign w_scl_rise = w_div_wrap && !r_scl;

  // Reading releases the line regardless of the selected source.
  assign w_level = ReadOrWrite ? 1'b1 : (Select ? r_shift[7] : StartStopAck);

  // Baud divider and SCL; disabling discards any partial half-period.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_div <= 16'd0;
      r_scl <= 1'b1;
    end else if (!BaudEnable) begin
      r_div <= 16'd0;
      r_scl <= 1'b1;
    end else if (w_div_wrap) begin
      r_div <= 16'd0;
      r_scl <= ~r_scl;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  // Transmit shift register: load beats shift.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_shift <= 8'h00;
    end else if (WriteLoad) begin
      r_shift <= WriteData;
    end else if (ShiftorHold) begin
      r_shift <= {r_shift[6:0], 1'b0};
    end
  end

  // Registered SDA drive; the pad itself is tied low, so oe is the inverse level.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_sda_level <= 1'b1;
      r_sda_oe    <= 1'b0;
    end else begin
      r_sda_level <= w_level;
      r_sda_oe    <= ~w_level;
    end
  end

  // SDA input synchronizer and acknowledge capture. The captured value is
  // sticky across transfers until the next capture.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_ack       <= 1'b0;
      r_ack_valid <= 1'b0;
    end else begin
      r_sync1     <= SDA_in;
      r_sync2     <= r_sync1;
      r_ack_valid <= 1'b0;
      if (ReadOrWrite && w_scl_rise) begin
        r_ack       <= ~r_sync2;
        r_ack_valid <= 1'b1;
      end
    end
  end

  assign ClockI2C    = r_scl;
  assign SDA_oe      = r_sda_oe;
  assign SDA_level   = r_sda_level;
  assign AckReceived = r_ack;
  assign AckValid    = r_ack_valid;
  assign ShiftData   = r_shift;

endmodule

// File: tb/tb_i2c_datapath.sv
// tb/tb_i2c_datapath.sv - self-checking bench for i2c_datapath

module tb_i2c_datapath;

  logic       clock = 1'b0;
  logic       Reset;
  logic       BaudEnable;
  logic       WriteLoad;
  logic       ShiftorHold;
  logic       Select;
  logic       StartStopAck;
  logic       ReadOrWrite;
  logic [7:0] WriteData;
  logic       SDA_in;
  logic       ClockI2C;
  logic       SDA_oe;
  logic       SDA_level;
  logic       AckReceived;
  logic       AckValid;
  logic [7:0] ShiftData;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_datapath #(.HALF_PERIOD(4)) dut (
    .clock        (clock),
    .Reset        (Reset),
    .BaudEnable   (BaudEnable),
    .WriteLoad    (WriteLoad),
    .ShiftorHold  (ShiftorHold),
    .Select       (Select),
    .StartStopAck (StartStopAck),
    .ReadOrWrite  (ReadOrWrite),
    .WriteData    (WriteData),
    .SDA_in       (SDA_in),
    .ClockI2C     (ClockI2C),
    .SDA_oe       (SDA_oe),
    .SDA_level    (SDA_level),
    .AckReceived  (AckReceived),
    .AckValid     (AckValid),
    .ShiftData    (ShiftData)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; BaudEnable = 1'b0; WriteLoad = 1'b0; ShiftorHold = 1'b0;
    Select = 1'b0; StartStopAck = 1'b1; ReadOrWrite = 1'b0; WriteData = 8'h00; SDA_in = 1'b1;
    tick(); tick();
    n_checks++; if (ClockI2C !== 1'b1) begin n_fail++; $display("FAIL reset_scl got %b want 1", ClockI2C); end
    n_checks++; if (SDA_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got %b want 0", SDA_oe); end
    n_checks++; if (SDA_level !== 1'b1) begin n_fail++; $display("FAIL reset_level got %b want 1", SDA_level); end
    n_checks++; if (ShiftData !== 8'h00) begin n_fail++; $display("FAIL reset_shift got %h want 00", ShiftData); end
    n_checks++; if (AckReceived !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", AckReceived); end
    n_checks++; if (AckValid !== 1'b0) begin n_fail++; $display("FAIL reset_ackvalid got %b want 0", AckValid); end
    Reset = 1'b0;
    tick();
  endtask

  // HALF_PERIOD = 4: first fall at edge 4, then a toggle every 4 edges.
  task automatic test_scl();
    logic exp_scl;
    BaudEnable = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      exp_scl = ((k / 4) % 2 == 0);
      n_checks++;
      if (ClockI2C !== exp_scl) begin
        n_fail++; $display("FAIL scl_edge%0d got %b want %b", k, ClockI2C, exp_scl);
      end
    end
    BaudEnable = 1'b0;
    tick();
    n_checks++; if (ClockI2C !== 1'b1) begin n_fail++; $display("FAIL scl_disable got %b want 1", ClockI2C); end
  endtask

  task automatic test_shift();
    logic [7:0] pattern;
    pattern = 8'hA5;
    Select = 1'b1; ReadOrWrite = 1'b0;
    WriteData = 8'hA5; WriteLoad = 1'b1;
    tick();
    WriteLoad = 1'b0;
    n_checks++; if (ShiftData !== 8'hA5) begin n_fail++; $display("FAIL shift_load got %h want a5", ShiftData); end
    tick();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (SDA_level !== pattern[7-i]) begin
        n_fail++; $display("FAIL shift_bit%0d level got %b want %b", i, SDA_level, pattern[7-i]);
      end
      n_checks++;
      if (SDA_oe !== ~pattern[7-i]) begin
        n_fail++; $display("FAIL shift_bit%0d oe got %b want %b", i, SDA_oe, ~pattern[7-i]);
      end
      ShiftorHold = 1'b1;
      tick();
      ShiftorHold = 1'b0;
      tick();
    end
    n_checks++; if (ShiftData !== 8'h00) begin n_fail++; $display("FAIL shift_end got %h want 00", ShiftData); end
  endtask

  task automatic test_load_priority();
    WriteData = 8'hFF; WriteLoad = 1'b1;
    tick();
    WriteData = 8'h3C; ShiftorHold = 1'b1;
    tick();
    WriteLoad = 1'b0; ShiftorHold = 1'b0;
    n_checks++; if (ShiftData !== 8'h3C) begin n_fail++; $display("FAIL load_priority got %h want 3c", ShiftData); end
    tick();
    n_checks++; if (ShiftData !== 8'h3C) begin n_fail++; $display("FAIL hold got %h want 3c", ShiftData); end
  endtask

  task automatic test_start_stop();
    Select = 1'b0; StartStopAck = 1'b1; ReadOrWrite = 1'b0;
    tick();
    n_checks++; if (SDA_oe !== 1'b0) begin n_fail++; $display("FAIL idle_oe got %b want 0", SDA_oe); end
    StartStopAck = 1'b0;
    n_checks++; if (SDA_oe !== 1'b0) begin n_fail++; $display("FAIL start_early got %b want 0", SDA_oe); end
    tick();
    n_checks++; if (SDA_oe !== 1'b1) begin n_fail++; $display("FAIL start_oe got %b want 1", SDA_oe); end
    n_checks++; if (SDA_level !== 1'b0) begin n_fail++; $display("FAIL start_level got %b want 0", SDA_level); end
    ReadOrWrite = 1'b1;
    tick();
    n_checks++; if (SDA_oe !== 1'b0) begin n_fail++; $display("FAIL release_oe got %b want 0", SDA_oe); end
  endtask

  // SCL rises at edge 8 and 16 after enable; capture shows after those edges.
  task automatic test_ack();
    logic exp_v, exp_a;
    ReadOrWrite = 1'b1; SDA_in = 1'b0; BaudEnable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 10) SDA_in = 1'b1;
      exp_v = (k == 8) || (k == 16);
      exp_a = (k >= 8) && (k < 16);
      n_checks++;
      if (AckValid !== exp_v) begin n_fail++; $display("FAIL ackvalid_edge%0d got %b want %b", k, AckValid, exp_v); end
      n_checks++;
      if (AckReceived !== exp_a) begin n_fail++; $display("FAIL ack_edge%0d got %b want %b", k, AckReceived, exp_a); end
    end
    BaudEnable = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    SDA_in = 1'b0; ReadOrWrite = 1'b1; BaudEnable = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = AckValid;
    end
    n_checks++; if (!seen || AckReceived !== 1'b1) begin n_fail++; $display("FAIL pre_reset_ack got %b want 1", AckReceived); end
    ReadOrWrite = 1'b0; Select = 1'b0; StartStopAck = 1'b0;
    WriteData = 8'hFF; WriteLoad = 1'b1;
    tick();
    WriteLoad = 1'b0;
    tick();
    n_checks++; if (SDA_oe !== 1'b1) begin n_fail++; $display("FAIL pre_reset_oe got %b want 1", SDA_oe); end
    #1 Reset = 1'b1;
    #1;
    n_checks++; if (ClockI2C !== 1'b1) begin n_fail++; $display("FAIL mid_reset_scl got %b want 1", ClockI2C); end
    n_checks++; if (SDA_oe !== 1'b0) begin n_fail++; $display("FAIL mid_reset_oe got %b want 0", SDA_oe); end
    n_checks++; if (ShiftData !== 8'h00) begin n_fail++; $display("FAIL mid_reset_shift got %h want 00", ShiftData); end
    n_checks++; if (AckReceived !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ack got %b want 0", AckReceived); end
    tick();
    Reset = 1'b0; BaudEnable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_scl();
    test_shift();
    test_load_priority();
    test_start_stop();
    test_ack();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
